// File: rtl/disp_sseg_mux_n.sv
// Multiplexed seven-segment display driver.
// Time-slices N_DIGITS digits onto shared segment lines, snapshots the digit
// inputs once per frame so the display never tears, and applies a PWM
// brightness gate inside each digit slot.
module disp_sseg_mux_n #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BRIGHT_W       = 4,
    parameter int AN_ACTIVE_LOW  = 0,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            sseg,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [BRIGHT_W-1:0]   dim;
    logic                  tc;
    logic                  snap;

    logic [7*N_DIGITS-1:0] sh_digits;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_blank;

    logic                  lit;
    logic [N_DIGITS-1:0]   an_next;
    logic [6:0]            sseg_next;
    logic                  dp_next;

    logic [N_DIGITS-1:0]   an_r;
    logic [6:0]            sseg_r;
    logic                  dp_r;
    logic                  frame_tick_r;

    assign tc   = (presc == PRESC_LAST);
    assign snap = tc && (idx == IDX_LAST);

    // Prescaler, slot index and PWM dim counter; the slot boundary restarts the dim phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= '0;
            dim   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (tc) begin
                presc <= '0;
                dim   <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
                dim   <= dim + 1'b1;
            end
        end
    end

    // Frame snapshot of the shadowed inputs, taken at the end of the last slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shadow set is a handful of flops, not a RAM, so it is
            // reset; blank resets high so the first frame after reset is dark.
            sh_digits    <= '0;
            sh_dp        <= '0;
            sh_blank     <= '1;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= snap;
            if (snap) begin
                sh_digits <= digits;
                sh_dp     <= dp;
                sh_blank  <= blank;
            end
        end
    end

    // Select the active digit and gate it with blank and the brightness duty.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        lit       = 1'b0;
        an_next   = '0;
        sseg_next = '0;
        dp_next   = 1'b0;
        if (!sh_blank[idx] && ((brightness == '1) || (dim < brightness))) begin
            lit = 1'b1;
        end
        if (lit) begin
            an_next   = AN_ONE << idx;
            sseg_next = sh_digits[7*int'(idx) +: 7];
            dp_next   = sh_dp[idx];
        end
    end

    // Output registers: one clock of latency from idx/dim to the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r   <= '0;
            sseg_r <= '0;
            dp_r   <= 1'b0;
        end else begin
            an_r   <= an_next;
            sseg_r <= sseg_next;
            dp_r   <= dp_next;
        end
    end

    // Polarity is a pure inversion after the registers, so it never adds latency.
    assign an         = (AN_ACTIVE_LOW != 0)  ? ~an_r   : an_r;
    assign sseg       = (SEG_ACTIVE_LOW != 0) ? ~sseg_r : sseg_r;
    assign dp_out     = (SEG_ACTIVE_LOW != 0) ? ~dp_r   : dp_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: doc/disp_sseg_mux_n.md
DISP_SSEG_MUX_N -- requirements
Module: disp_sseg_mux_n

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, meaning the digit count; legal range 2..8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit slot; legal minimum 2^BRIGHT_W.
REQ-003 The block SHALL have parameter BRIGHT_W, default 4, meaning the brightness field width.
REQ-004 The block SHALL have parameter AN_ACTIVE_LOW, default 0, meaning that when 1 the an outputs are inverted.
REQ-005 The block SHALL have parameter SEG_ACTIVE_LOW, default 0, meaning that when 1 the sseg and dp_out outputs are inverted.
REQ-006 The block SHALL have port clk, input, width 1: the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n, input, width 1: asynchronous reset, active-low.
REQ-008 The block SHALL have port digits, input, width 7*N_DIGITS: segment pattern for each digit; digit k is in bits [7k+6:7k], bit 0 is segment a.
REQ-009 The block SHALL have port dp, input, width N_DIGITS: decimal point request for each digit.
REQ-010 The block SHALL have port blank, input, width N_DIGITS: per-digit blank; 1 forces that digit dark.
REQ-011 The block SHALL have port brightness, input, width BRIGHT_W: global duty level.
REQ-012 The block SHALL have port an, output, width N_DIGITS: one-hot anode enables.
REQ-013 The block SHALL have port sseg, output, width 7: segment drive for the active digit.
REQ-014 The block SHALL have port dp_out, output, width 1: decimal point drive for the active digit.
REQ-015 The block SHALL have port frame_tick, output, width 1: a one-cycle pulse that fires when the shadow registers load.

Function
REQ-016 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its terminal count is REFRESH_DIV-1.
REQ-017 The slot index SHALL advance on the prescaler terminal count and wrap from N_DIGITS-1 to 0.
REQ-018 The dim counter SHALL be BRIGHT_W bits, increment every clk, and clear at each prescaler terminal count.
REQ-019 On the cycle where slot index = N_DIGITS-1 and the prescaler is at terminal count, the block SHALL copy digits, dp and blank into shadow registers.
REQ-020 frame_tick SHALL be registered and high on the cycle after that same cycle (REQ-019).
REQ-021 Display SHALL use only shadow values, so input changes mid-frame cannot tear the display.
REQ-022 The digit is lit when shadow blank[idx] = 0 and one of these holds: brightness is all-ones, or dim counter < brightness.
REQ-023 Brightness 0 SHALL keep every digit dark.
REQ-024 When lit, an SHALL be the one-hot of idx, sseg SHALL be shadow digits[idx], and dp_out SHALL be shadow dp[idx].
REQ-025 When not lit, an, sseg and dp_out SHALL all be inactive (0 before polarity inversion).
REQ-026 an, sseg and dp_out SHALL be registered, with one clk of latency from the idx and dim counter values.
REQ-027 Polarity inversion SHALL be applied after the registers, as a combinational inversion only.
REQ-028 An input change on the snapshot cycle SHALL be captured if it is present at that clock edge.
REQ-029 A brightness change SHALL take effect immediately; it is not shadowed.
REQ-030 At most one an bit SHALL ever be active.

Reset
REQ-031 While reset_n = 0, the prescaler, dim counter and idx SHALL be 0, frame_tick SHALL be 0, and the shadow digits and dp SHALL be 0.
REQ-032 While reset_n = 0, shadow blank SHALL be all-ones, so the first frame after reset is dark.
REQ-033 While reset_n = 0, an, sseg and dp_out SHALL be at their inactive level.
REQ-034 Reset asserted mid-frame SHALL clear all state immediately, asynchronously to clk.
REQ-035 Release of reset SHALL be synchronous to clk: counting starts on the first rising edge with reset_n = 1.

Verification
REQ-036 The bench SHALL check: N_DIGITS=4, REFRESH_DIV=8, BRIGHT_W=2, brightness=3, blank=0, digits={7'h06,7'h5B,7'h4F,7'h66} -> after the first frame_tick, an cycles 0001,0010,0100,1000 for 8 clk each, with sseg matching that digit.
REQ-037 The bench SHALL check: the same setup with brightness=1 -> in each slot the digit is lit on exactly 2 of 8 clk (dim counter values 0, in each half of the slot), and an is 0 otherwise.
REQ-038 The bench SHALL check: digits changed while idx=1 -> sseg keeps the old patterns until the next frame_tick, then shows the new ones.
REQ-039 The bench SHALL check: blank=4'b0100 and dp=4'b0001 -> an never shows 0100; dp_out = 1 only during slot 0.
REQ-040 The bench SHALL check: AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1 -> while reset_n = 0, an = 4'hF, sseg = 7'h7F and dp_out = 1; in run, the outputs are the bitwise inverse of the default-polarity run.
REQ-041 The bench SHALL check: reset_n pulsed low while idx=2 -> all outputs go inactive with no clk edge, idx returns to 0, and the first frame after release is dark.
